// File: rtl/proc_pkg.sv
// Shared opcodes, instruction constants and sequencer state type for the 8-bit core.
package proc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [7:0] INSTR_NOP = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } seq_state_t;

    function automatic logic is_halt(input logic [7:0] word);
        return word[7:4] == OP_HALT;
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x 8, written on the clock edge, read combinationally by address.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // NOTE: no reset on the array; program contents must survive rst and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues program words to the core one at a time, holds each ISSUE_GAP cycles, then captures result and flags.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int ISSUE_GAP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          start,
    output logic [7:0]    instr,
    input  logic [7:0]    result_in,
    input  logic          zero_in,
    input  logic          carry_in,
    input  logic          ovf_in,
    output logic          res_valid,
    output logic [7:0]    res_data,
    output logic [2:0]    res_flags,
    output logic [AW-1:0] res_pc,
    output logic          busy,
    output logic          done
);

    localparam int CW = 4;

    seq_state_t    r_state;
    seq_state_t    w_next_state;
    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_instr;
    logic          r_res_valid;
    logic [7:0]    r_res_data;
    logic [2:0]    r_res_flags;
    logic [AW-1:0] r_res_pc;
    logic [7:0]    w_mem_rdata;
    logic          w_mem_we;
    logic          w_last_pc;

    // Host writes are only honoured while idle so a running program never changes under the issuer.
    assign w_mem_we  = prog_we && (r_state == IDLE);
    assign w_last_pc = (r_pc == AW'(DEPTH - 1));

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = ISSUE;
            ISSUE:   w_next_state = is_halt(w_mem_rdata) ? DONE : WAIT;
            WAIT:    if (r_cnt == '0) w_next_state = CAPTURE;
            CAPTURE: w_next_state = w_last_pc ? DONE : ISSUE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_cnt       <= '0;
            r_instr     <= INSTR_NOP;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_pc    <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) r_pc <= '0;
                end
                ISSUE: begin
                    if (!is_halt(w_mem_rdata)) begin
                        r_instr <= w_mem_rdata;
                        r_cnt   <= CW'(ISSUE_GAP - 1);
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                CAPTURE: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= result_in;
                    r_res_flags <= {zero_in, carry_in, ovf_in};
                    r_res_pc    <= r_pc;
                    if (!w_last_pc) r_pc <= r_pc + 1'b1;
                end
                DONE: begin
                    r_instr <= INSTR_NOP;
                end
                default: ;
            endcase
        end
    end

    assign instr     = r_instr;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign res_pc    = r_res_pc;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: stub core, timeline-based reference model, directed scenarios plus randomized runs.
module tb_instr_sequencer;
    import proc_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GAP   = 2;
    localparam int P     = GAP + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          start;
    logic [7:0]    instr;
    logic [7:0]    result_in;
    logic          zero_in, carry_in, ovf_in;
    logic          res_valid;
    logic [7:0]    res_data;
    logic [2:0]    res_flags;
    logic [AW-1:0] res_pc;
    logic          busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .ISSUE_GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .instr     (instr),
        .result_in (result_in),
        .zero_in   (zero_in),
        .carry_in  (carry_in),
        .ovf_in    (ovf_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_flags (res_flags),
        .res_pc    (res_pc),
        .busy      (busy),
        .done      (done)
    );

    // Stub core: two fixed operand registers; returns {zero,carry,ovf,result}.
    // SUB reports borrow on the ovf pin; other opcodes clear carry/ovf.
    logic [7:0] core_a, core_b, core_ir;

    function automatic logic [10:0] core_fn(input logic [7:0] w, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (w[7:4])
            OP_NOP: r = 8'h00;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                r = a - b;
                v = (a < b);
            end
            default: r = a ^ b;
        endcase
        return {(r == 8'h00), c, v, r};
    endfunction

    always @(posedge clk) core_ir <= instr;
    always_comb {zero_in, carry_in, ovf_in, result_in} = core_fn(core_ir, core_a, core_b);

    // Reference model: on an accepted start, snapshot the program and derive every event
    // from its cycle offset t after the start edge (issue at k*P+1, result at (k+1)*P).
    logic [7:0]    m_mem  [DEPTH];
    logic [7:0]    m_prog [DEPTH];
    bit            m_busy = 1'b0;
    bit            m_halted;
    int            m_t, m_n, m_d;
    logic [7:0]    e_instr, e_data;
    logic          e_valid, e_done;
    logic [2:0]    e_flags;
    logic [AW-1:0] e_pc;

    always @(posedge clk) begin
        e_valid = 1'b0;
        if (rst) begin
            m_busy  = 1'b0;
            e_instr = 8'h00;
            e_data  = 8'h00;
            e_flags = 3'b000;
            e_pc    = '0;
            e_done  = 1'b0;
        end else if (!m_busy) begin
            e_done = 1'b0;
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                m_busy   = 1'b1;
                m_t      = 0;
                m_prog   = m_mem;
                m_n      = DEPTH;
                m_halted = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (!m_halted && m_prog[k][7:4] == OP_HALT) begin
                        m_n      = k;
                        m_halted = 1'b1;
                    end
                end
                m_d = m_halted ? m_n * P + 1 : m_n * P;
            end
        end else begin
            m_t++;
            if (m_t % P == 0 && m_t / P >= 1 && m_t / P <= m_n) begin
                {e_flags, e_data} = core_fn(m_prog[m_t / P - 1], core_a, core_b);
                e_pc    = AW'(m_t / P - 1);
                e_valid = 1'b1;
            end
            if (m_t % P == 1 && m_t / P < m_n) e_instr = m_prog[m_t / P];
            e_done = (m_t == m_d);
            if (m_t == m_d + 1) begin
                m_busy  = 1'b0;
                e_instr = 8'h00;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         pc;
        logic [7:0] data;
        logic [2:0] flags;
        int         cyc;
    } obs_t;

    obs_t obs[$];
    int   done_cnt   = 0;
    int   cyc        = 0;
    bit   chk_en     = 1'b0;
    bit   saw_halt_i = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("cycle {instr,valid,data,flags,pc,busy,done}",
                  32'({instr, res_valid, res_data, res_flags, res_pc, busy, done}),
                  32'({e_instr, e_valid, e_data, e_flags, e_pc, m_busy, e_done}));
            if (res_valid) obs.push_back('{int'(res_pc), res_data, res_flags, cyc});
            if (done) done_cnt++;
            if (instr[7:4] == OP_HALT) saw_halt_i = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        check("idle reached within budget", 32'(busy), 32'(0));
    endtask

    task automatic clear_log();
        obs.delete();
        done_cnt   = 0;
        saw_halt_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        prog_we   = 1'b0;
        start     = 1'b0;
        prog_addr = '0;
        prog_data = 8'h00;
        core_a    = 8'h01;
        core_b    = 8'h02;

        // 1: reset
        tick();
        chk_en = 1'b1;
        tick();
        check("reset instr", 32'(instr), 32'h00);
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset res_valid", 32'(res_valid), 32'(0));
        rst = 1'b0;

        // 2: ADD, SUB, HALT
        clear_log();
        write_word(0, 8'h10);
        write_word(1, 8'h20);
        write_word(2, 8'hF0);
        pulse_start();
        wait_idle(200);
        check("t2 result count", 32'(obs.size()), 32'(2));
        if (obs.size() >= 2) begin
            check("t2 r0 pc", 32'(obs[0].pc), 32'(0));
            check("t2 r0 data", 32'(obs[0].data), 32'h03);
            check("t2 r0 flags", 32'(obs[0].flags), 32'b000);
            check("t2 r1 pc", 32'(obs[1].pc), 32'(1));
            check("t2 r1 data", 32'(obs[1].data), 32'hFF);
            check("t2 r1 flags", 32'(obs[1].flags), 32'b001);
            check("t2 pulse spacing", 32'(obs[1].cyc - obs[0].cyc), 32'(4));
        end
        check("t2 done count", 32'(done_cnt), 32'(1));
        check("t2 halt word never on instr", 32'(saw_halt_i), 32'(0));

        // 3: full memory of ADDs, no wrap
        clear_log();
        for (int i = 0; i < DEPTH; i++) write_word(i, 8'h10);
        pulse_start();
        wait_idle(300);
        check("t3 result count", 32'(obs.size()), 32'(16));
        for (int i = 0; i < obs.size(); i++) begin
            check("t3 pc", 32'(obs[i].pc), 32'(i));
            check("t3 data", 32'(obs[i].data), 32'h03);
        end
        check("t3 done count", 32'(done_cnt), 32'(1));

        // 4: write and start while busy are ignored
        clear_log();
        write_word(0, 8'h10);
        write_word(1, 8'h20);
        write_word(2, 8'hF0);
        pulse_start();
        tick();
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 8'hF0;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        wait_idle(200);
        check("t4 result count", 32'(obs.size()), 32'(2));
        if (obs.size() >= 2) check("t4 r1 data", 32'(obs[1].data), 32'hFF);
        check("t4 done count", 32'(done_cnt), 32'(1));

        // 5: reset during WAIT of pc1
        clear_log();
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 instr after rst", 32'(instr), 32'h00);
        check("t5 busy after rst", 32'(busy), 32'(0));
        check("t5 res_valid after rst", 32'(res_valid), 32'(0));
        tick();
        check("t5 results before rst", 32'(obs.size()), 32'(1));
        check("t5 no done", 32'(done_cnt), 32'(0));
        clear_log();
        pulse_start();
        wait_idle(200);
        if (obs.size() >= 1) check("t5 rerun first data", 32'(obs[0].data), 32'h03);
        check("t5 rerun result count", 32'(obs.size()), 32'(2));

        // 6: HALT at pc0
        clear_log();
        write_word(0, 8'hF0);
        pulse_start();
        check("t6 done 1st cycle", 32'(done), 32'(0));
        tick();
        check("t6 done 2nd cycle", 32'(done), 32'(1));
        tick();
        check("t6 busy after done", 32'(busy), 32'(0));
        check("t6 no results", 32'(obs.size()), 32'(0));

        // Randomized runs: random programs, operands, busy-time pokes and occasional reset.
        for (int run = 0; run < 40; run++) begin
            core_a = 8'($urandom);
            core_b = 8'($urandom);
            for (int i = 0; i < DEPTH; i++) begin
                prog_we   = 1'b1;
                prog_addr = AW'(i);
                prog_data = ($urandom_range(0, 7) == 0) ? {4'hF, 4'($urandom)}
                                                         : {4'($urandom_range(0, 14)), 4'($urandom)};
                start     = (i == DEPTH - 1) && ($urandom_range(0, 2) == 0);
                tick();
            end
            prog_we = 1'b0;
            if (!busy) pulse_start();
            start = 1'b0;
            for (int c = 0; c < 200 && busy; c++) begin
                prog_we   = ($urandom_range(0, 3) == 0);
                start     = ($urandom_range(0, 3) == 0);
                prog_addr = AW'($urandom);
                prog_data = 8'($urandom);
                rst       = ($urandom_range(0, 149) == 0);
                tick();
            end
            prog_we = 1'b0;
            start   = 1'b0;
            rst     = 1'b0;
            check("random run idle", 32'(busy), 32'(0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
